mem_tracked: RTL and testbench

Parametrised single-clock RAM with independent write and read ports, per-byte write enables and per-location written-tracking. Successor to the basic `memory` block. It adds:
- a registered read port with valid/hit qualifiers;
- an occupancy counter, with `full`/`empty` derived from it;
- a synchronous bulk clear.

It sits between the code-generator datapath and its table/buffer storage wherever "has this slot been filled yet" must be known.

---
 rtl/mem_tracked.sv | 124 ++++++++++++
 tb/tb_mem_tracked.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tracked.sv
// mem_tracked: single-clock RAM with byte-enabled write port, registered
// read port, per-location written flags, occupancy counter and bulk clear.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   wr_en/wr_addr/wr_data/wr_be  write request, address, data, byte enables
//   rd_en/rd_addr             read request and address
//   clr                       synchronous clear of all written flags
//   rd_data/rd_valid/rd_hit   registered read result (1-cycle latency)
//   used/full/empty           count of written locations and its decodes
//
// Build option: define MEM_BYPASS_EN to forward a same-cycle, same-address
// write into the read result; otherwise the read sees the pre-write state.
module mem_tracked #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    input  logic               clr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               rd_hit,
    output logic [AW:0]        used,
    output logic               full,
    output logic               empty
);

    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [AW:0]      used_q, used_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;
    logic             rd_hit_q, rd_hit_d;

    logic             wr_act;
    logic [WIDTH-1:0] wr_base;
    logic [WIDTH-1:0] wr_word;

    // A write with no byte enabled, or one coinciding with clr, does nothing.
    assign wr_act = wr_en && (wr_be != '0) && !clr;

    // Unwritten locations merge against zero so stale array contents never
    // leak into a partially written word.
    assign wr_base = written_q[wr_addr] ? mem_q[wr_addr] : '0;

    always_comb begin
        wr_word = wr_base;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                wr_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_hit_d  = written_q[rd_addr];
        rd_data_d = rd_hit_d ? mem_q[rd_addr] : '0;
`ifdef MEM_BYPASS_EN
        if (wr_act && (wr_addr == rd_addr)) begin
            rd_hit_d  = 1'b1;
            rd_data_d = wr_word;
        end
`endif
    end

    always_comb begin
        written_d = written_q;
        used_d    = used_q;
        if (clr) begin
            written_d = '0;
            used_d    = '0;
        end else if (wr_act) begin
            written_d[wr_addr] = 1'b1;
            if (!written_q[wr_addr]) begin
                used_d = used_q + ONE_CNT;
            end
        end
    end

    // Data array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_act) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q  <= '0;
            used_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            written_q  <= written_d;
            used_q     <= used_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
                rd_hit_q  <= rd_hit_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign used     = used_q;
    assign full     = (used_q == FULL_CNT);
    assign empty    = (used_q == '0);

endmodule

// File: tb/tb_mem_tracked.sv
// tb_mem_tracked: directed test of mem_tracked against a behavioural model
// with a per-cycle compare process and literal spot checks.
module tb_mem_tracked;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W/8-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_hit;
    logic [AW:0]   used;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    mem_tracked #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .clr(clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit),
        .used(used), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Behavioural model: contents, written flags and expected read result.
    logic [W-1:0] m_mem [D];
    bit           m_wr  [D];
    bit           e_valid;
    logic [W-1:0] e_data;
    bit           e_hit;

    function automatic logic [W-1:0] merged(input int a, input logic [W-1:0] d,
                                            input logic [W/8-1:0] be);
        logic [W-1:0] r;
        r = m_wr[a] ? m_mem[a] : '0;
        for (int i = 0; i < W / 8; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < D; i++) n += m_wr[i] ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit wact;
        if (rst) begin
            for (int i = 0; i < D; i++) m_wr[i] = 1'b0;
            e_valid = 1'b0;
            e_data  = '0;
            e_hit   = 1'b0;
        end else begin
            wact = wr_en && (wr_be != 0) && !clr;
            e_valid = rd_en;
            if (rd_en) begin
                e_hit  = m_wr[rd_addr];
                e_data = e_hit ? m_mem[rd_addr] : '0;
`ifdef MEM_BYPASS_EN
                if (wact && wr_addr == rd_addr) begin
                    e_hit  = 1'b1;
                    e_data = merged(int'(wr_addr), wr_data, wr_be);
                end
`endif
            end
            if (clr) begin
                for (int i = 0; i < D; i++) m_wr[i] = 1'b0;
            end else if (wact) begin
                m_mem[wr_addr] = merged(int'(wr_addr), wr_data, wr_be);
                m_wr[wr_addr]  = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int n;
        if (chk) begin
            n = m_used();
            check("m_valid", 64'(rd_valid), 64'(e_valid));
            check("m_data", 64'(rd_data), 64'(e_data));
            check("m_hit", 64'(rd_hit), 64'(e_hit));
            check("m_used", 64'(used), 64'(n));
            check("m_full", 64'(full), 64'(n == D));
            check("m_empty", 64'(empty), 64'(n == 0));
        end
    end

    task automatic drive(input bit we, input int wa, input logic [W-1:0] wd,
                         input logic [W/8-1:0] be, input bit re, input int ra,
                         input bit c);
        @(negedge clk);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = AW'(ra);
        clr     = c;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d, input logic [W/8-1:0] be);
        drive(1, a, d, be, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        drive(0, 0, '0, '0, 1, a, 0);
    endtask

    initial begin
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 0; rd_addr = '0; clr = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_hit", 64'(rd_hit), 64'd0);
        check("rst_used", 64'(used), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        rst = 1'b0;
        chk = 1'b1;

        // Unwritten read
        rd(5);
        idle();
        check("t1_valid", 64'(rd_valid), 64'd1);
        check("t1_data", 64'(rd_data), 64'd0);
        check("t1_hit", 64'(rd_hit), 64'd0);

        // Byte-enable merge
        wr(3, 32'hAABBCCDD, 4'b1111);
        wr(3, 32'h11223344, 4'b0101);
        rd(3);
        idle();
        check("t2_data", 64'(rd_data), 64'hAA22CC44);
        check("t2_hit", 64'(rd_hit), 64'd1);
        check("t2_used", 64'(used), 64'd1);

        // be=0 is a no-op
        wr(4, 32'hDEADBEEF, 4'b0000);
        rd(4);
        idle();
        check("noop_hit", 64'(rd_hit), 64'd0);
        check("noop_used", 64'(used), 64'd1);

        // Fill to full, then rewrite
        for (int a = 0; a < D; a++) wr(a, W'(a * 3 + 1), 4'hF);
        idle();
        check("t3_used", 64'(used), 64'(D));
        check("t3_full", 64'(full), 64'd1);
        wr(0, 32'h5555_0000, 4'hF);
        idle();
        check("t3_used_rw", 64'(used), 64'(D));
        check("t3_full_rw", 64'(full), 64'd1);

        // Same-cycle collision
        wr(7, 32'h1, 4'hF);
        drive(1, 7, 32'h2, 4'hF, 1, 7, 0);
        rd(7);
`ifdef MEM_BYPASS_EN
        check("t4_coll", 64'(rd_data), 64'h2);
`else
        check("t4_coll", 64'(rd_data), 64'h1);
`endif
        idle();
        check("t4_next", 64'(rd_data), 64'h2);

        // Clear priority
        drive(0, 0, '0, '0, 0, 0, 1);
        wr(1, 32'h0101_0101, 4'hF);
        wr(2, 32'h0202_0202, 4'hF);
        wr(3, 32'h0303_0303, 4'hF);
        wr(4, 32'h0404_0404, 4'hF);
        idle();
        check("t5_used4", 64'(used), 64'd4);
        drive(1, 9, 32'h9999_9999, 4'hF, 1, 1, 1);
        rd(9);
        check("t5_rd_data", 64'(rd_data), 64'h0101_0101);
        check("t5_rd_hit", 64'(rd_hit), 64'd1);
        check("t5_used0", 64'(used), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        idle();
        check("t5_9hit", 64'(rd_hit), 64'd0);
        check("t5_9data", 64'(rd_data), 64'd0);

        // Reset while a read is in flight
        wr(2, 32'h2222_2222, 4'hF);
        rd(2);
        @(posedge clk);
        rd_en = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("t6_valid", 64'(rd_valid), 64'd0);
        check("t6_used", 64'(used), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_hit", 64'(rd_hit), 64'd0);
        rst = 1'b0;
        wr(6, 32'hCAFE_F00D, 4'b0011);
        rd(6);
        idle();
        check("t6_partial", 64'(rd_data), 64'h0000_F00D);

        // Mixed traffic checked by the model only
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                  W'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                  $urandom_range(0, 31) == 0);
        end
        idle();
        idle();

        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
